// File: rtl/sha256_2_pipeline.sv
`default_nettype none
// sha256_2_pipeline: 131-stage unrolled double SHA-256 (midstate + 16-byte tail), one digest per clock.
// Revision 1.0 - initial release
module sha256_2_pipeline (
  input  logic         CLK,
  input  logic         RST,
  input  logic         write_en,
  input  logic [255:0] digest_intial,
  input  logic [255:0] digest_in,
  input  logic [127:0] block_in,
  output logic [255:0] digest_out,
  output logic         valid_out
);

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                             input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // Window holds W[t..t+15] with W[t] in the top word; slide by one and append W[t+16].
  function automatic logic [511:0] sched(input logic [511:0] w);
    logic [31:0] w0, w1, w9, w14, s0, s1;
    w0  = w[511:480];
    w1  = w[479:448];
    w9  = w[223:192];
    w14 = w[63:32];
    s0  = rotr(w1, 7) ^ rotr(w1, 18) ^ (w1 >> 3);
    s1  = rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10);
    return {w[479:0], w0 + s0 + w9 + s1};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[255-32*i -: 32] = x[255-32*i -: 32] + y[255-32*i -: 32];
    end
    return r;
  endfunction

  logic [255:0] st_q [0:129];
  logic [511:0] w_q  [0:128];
  logic [255:0] ff_q [0:64];
  logic [255:0] st_d [1:129];
  logic [511:0] w_d  [1:128];
  logic [130:0] vld_q;

  // Stage 65 restarts the state at the IV with the padded hash-1 digest as its block.
  always_comb begin
    for (int s = 1; s < 130; s++) begin
      if (s == 65) begin
        st_d[s] = IV;
      end else begin
        st_d[s] = sha_round(st_q[s-1], K[6'((s < 65) ? (s - 1) : (s - 66))], w_q[s-1][511:480]);
      end
    end
    for (int s = 1; s < 129; s++) begin
      if (s == 65) begin
        w_d[s] = {add8(ff_q[64], st_q[64]), 32'h80000000, 192'd0, 32'h00000100};
      end else begin
        w_d[s] = sched(w_q[s-1]);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (write_en) begin
      st_q[0] <= digest_in;
      ff_q[0] <= digest_intial;
      w_q[0]  <= {block_in, 32'h80000000, 320'd0, 32'h00000280};
    end
    for (int s = 1; s < 130; s++) st_q[s] <= st_d[s];
    for (int s = 1; s < 129; s++) w_q[s]  <= w_d[s];
    for (int s = 1; s < 65; s++)  ff_q[s] <= ff_q[s-1];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q      <= '0;
      digest_out <= '0;
    end else begin
      vld_q      <= {vld_q[129:0], write_en};
      digest_out <= add8(IV, st_q[129]);
    end
  end

  assign valid_out = vld_q[130];

endmodule
`default_nettype wire

// File: tb/tb_sha256_2_pipeline.sv
`default_nettype none
// tb_sha256_2_pipeline: scoreboard bench for the double SHA-256 pipeline.
module tb_sha256_2_pipeline;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] MID =
    256'hF59007B57A2E5616B8F47922F4A62AA5F6F596588185BBAEFA09E7763BC75771;
  localparam logic [127:0] TAIL = 128'h252db801130dae516461011a3aeb9bb8;
  localparam int LAT = 130;

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         CLK = 1'b0;
  logic         RST;
  logic         write_en;
  logic [255:0] digest_intial;
  logic [255:0] digest_in;
  logic [127:0] block_in;
  logic [255:0] digest_out;
  logic         valid_out;

  sha256_2_pipeline dut (
    .CLK           (CLK),
    .RST           (RST),
    .write_en      (write_en),
    .digest_intial (digest_intial),
    .digest_in     (digest_in),
    .block_in      (block_in),
    .digest_out    (digest_out),
    .valid_out     (valid_out)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    logic [255:0] dig;
    int unsigned  ecyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression: full 64-entry schedule expanded up front, then 64 rounds.
  function automatic logic [255:0] m_compress(input logic [255:0] st, input logic [255:0] chain,
                                              input logic [511:0] blk);
    logic [31:0]  w [0:63];
    logic [31:0]  v [0:7];
    logic [31:0]  s0, s1, t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = st[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
           + KT[i] + w[i];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    res = '0;
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = chain[255-32*i -: 32] + v[i];
    return res;
  endfunction

  function automatic logic [255:0] model_d(input logic [255:0] di, input logic [255:0] dn,
                                           input logic [127:0] blk);
    logic [255:0] h1;
    h1 = m_compress(dn, di, {blk, 32'h80000000, 320'd0, 32'h00000280});
    return m_compress(IV, IV, {h1, 32'h80000000, 192'd0, 32'h00000100});
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Inputs change at posedge+3; the job is sampled by the following edge.
  task automatic drive(input logic we, input logic [255:0] di, input logic [255:0] dn,
                       input logic [127:0] blk);
    exp_t e;
    write_en      = we;
    digest_intial = di;
    digest_in     = dn;
    block_in      = blk;
    if (we) begin
      e.dig  = model_d(di, dn, blk);
      e.ecyc = cyc + 1 + LAT;
      sb.push_back(e);
    end
    @(posedge CLK);
    #3;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0);
  endtask

  always @(posedge CLK) begin : mon
    exp_t e;
    #1;
    if (sb.size() > 0 && sb[0].ecyc == cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (valid_out !== 1'b1 || digest_out !== e.dig) begin
        n_bad++;
        $display("FAIL result cyc=%0d valid_out=%b digest_out=%h required valid_out=1 digest_out=%h",
                 cyc, valid_out, digest_out, e.dig);
      end
    end else if (valid_out !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_valid cyc=%0d valid_out=%b required 0", cyc, valid_out);
    end
  end

  initial begin
    logic [95:0]  hi;
    int unsigned  tgt;
    hi            = TAIL[127:32];
    RST           = 1'b1;
    write_en      = 1'b0;
    digest_intial = '0;
    digest_in     = '0;
    block_in      = '0;
    #1 RST = 1'b0;
    repeat (5) @(posedge CLK);
    #3;
    check("reset_valid", {255'd0, valid_out}, 256'd0);
    check("reset_digest", digest_out, 256'd0);
    RST = 1'b1;

    // Reference model against the FIPS 180-4 "abc" vector.
    check("model_abc", m_compress(IV, IV, {32'h61626380, 448'd0, 32'h00000018}),
          256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    drive(1'b1, MID, MID, TAIL);
    idle(LAT + 5);

    drive(1'b1, IV, 256'd0, 128'hdeadbeef_00000000_12345678_9abcdef0);
    idle(LAT + 5);

    for (int i = 0; i < 200; i++) drive(1'b1, MID, MID, {hi, 32'(i)});
    idle(LAT + 5);

    for (int i = 0; i < 20; i++) drive((i % 2) == 0, MID, MID, {hi, 32'(1000 + i)});
    idle(LAT + 5);

    // Asynchronous reset while a result is on the output and more are in flight.
    tgt = cyc + 1 + LAT;
    drive(1'b1, MID, MID, {hi, 32'h0000beef});
    for (int i = 0; i < 5; i++) drive(1'b1, IV, MID, {hi, 32'(2000 + i)});
    for (int i = 0; i < 200 && cyc < tgt; i++) idle(1);
    check("pre_reset_valid", {255'd0, valid_out}, 256'd1);
    RST = 1'b0;
    #1;
    check("async_reset_valid", {255'd0, valid_out}, 256'd0);
    check("async_reset_digest", digest_out, 256'd0);
    sb.delete();
    idle(3);
    RST = 1'b1;
    idle(LAT + 10);

    // Reset pulse between edges at cycle 60 of a stream.
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, MID, MID, {hi, 32'(5000 + i)});
      if (i == 60) begin
        RST = 1'b0;
        #1;
        sb.delete();
        RST = 1'b1;
        #1;
      end
    end
    idle(LAT + 5);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha256_2_pipeline.md
Name: sha256_2_pipeline

Overview:
- Fully unrolled, one-round-per-stage double SHA-256 pipeline for Bitcoin header hashing.
- Takes a precomputed midstate (SHA-256 of the first 64 header bytes) and the last 16 header bytes.
- Computes SHA-256(SHA-256(header)) at one result per clock, fixed latency.
- Sits between the work/nonce generator and the target comparator.

Parameters:
- None. Round count (64 per hash), K constants and the standard IV are fixed.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-low reset
- write_en  in  1  high: sample the inputs this edge as a new job
- digest_intial  in  256  chaining value H0..H7 added after hash-1 rounds; [255:224]=H0
- digest_in  in  256  working state a..h loaded into hash-1 round 0; [255:224]=a. Normally equal to digest_intial.
- block_in  in  128  last 16 header bytes: [127:96]=W0, [95:64]=W1, [63:32]=W2, [31:0]=W3
- digest_out  out  256  double-hash result; [255:224]=H0 of hash 2
- valid_out  out  1  digest_out holds a result this cycle

Behaviour:
- Reset:
  - RST low asynchronously clears every stage valid bit, valid_out and digest_out to 0.
  - Data pipeline registers need not be reset.
- Stage 0, input register: on an edge with write_en=1, capture digest_intial, digest_in and block_in; stage-0 valid is set to write_en.
- Hash 1 message block:
  - W0..W3 = block_in.
  - W4 = 0x80000000; W5..W14 = 0; W15 = 0x00000280.
- Hash 1 rounds: stages 1..64, one SHA-256 round each.
  - Wt for t≥16 is computed via σ0/σ1 and carried in a sliding 16-word window per stage.
  - All arithmetic is mod 2^32.
- Stage 65, feed-forward and padding:
  - H1_i = digest_intial_i + final working variable i.
  - Hash 2 block: W0..W7 = H1_0..H1_7, W8 = 0x80000000, W9..W14 = 0, W15 = 0x00000100.
  - Hash 2 state is the standard IV: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- Hash 2 rounds: stages 66..129.
- Stage 130, output: digest_out = IV_i + final working variables; valid_out = stage valid.
- Latency and throughput:
  - Job sampled at edge k produces valid_out=1 and its digest_out after edge k+130.
  - One job accepted per clock; no back-pressure.
  - Back-to-back jobs produce back-to-back results in order.
- write_en low: a bubble propagates and valid_out is low exactly 130 cycles later. digest_out may hold stale data when valid_out=0.
- Reset mid-operation: all in-flight jobs are discarded. After RST rises, valid_out stays 0 until 130 edges after the first post-reset write_en.
- Valid bits travel in a 131-bit shift chain parallel to the data.
- Byte order: no byte swapping; words are big-endian as in FIPS 180-4.

Test Plan:
- Basic job:
  - Stimulus: reset low 5 cycles, then release; write_en=1 once; digest_intial = digest_in = F59007B57A2E5616B8F47922F4A62AA5F6F596588185BBAEFA09E7763BC75771; block_in = 252db801130dae516461011a3aeb9bb8.
  - Response: valid_out high exactly 130 cycles later, for 1 cycle; digest_out equals a software double SHA-256 model using the same midstate/tail.
- Reset:
  - Stimulus: RST asserted asynchronously between clock edges.
  - Response: valid_out=0 and digest_out=0 immediately; no pulse afterwards from jobs issued before reset.
- Streaming:
  - Stimulus: write_en=1 for 200 consecutive cycles, block_in[31:0] (nonce) incrementing from 0.
  - Response: 200 consecutive valid_out cycles starting at +130, each digest matching the model for its nonce, in order.
- Bubbles:
  - Stimulus: alternating write_en 1/0.
  - Response: valid_out alternates identically, delayed 130 cycles.
- Separate state inputs:
  - Stimulus: digest_in ≠ digest_intial (digest_in = 0, digest_intial = IV).
  - Response: digest_out matches a model using digest_in as round-0 state and digest_intial as feed-forward.
- Reset mid-stream:
  - Stimulus: RST pulsed low at cycle 60 of a stream.
  - Response: no valid_out until 130 cycles after the first post-reset write_en.
